sprite_engine: RTL and testbench
================================

SPRITE_ENGINE -- requirements
Module: sprite_engine

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_SPR, 4: number of hardware sprites.
- SPR_DIM, 16: sprite edge in pixels; power of two.
- PIX_W, 4: pixel colour width.
- COORD_W, 12: raster coordinate width.
- TRANSP_CLR, 0: colour index treated as transparent.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- vga_clk, in, 1: sole clock, rising edge.
- rst_n, in, 1: reset, synchronous, active-low.
- pos_we, in, 1: position/enable write strobe.
- pos_spr, in, clog2(NUM_SPR): target sprite for position write.
- pos_row, in, COORD_W: sprite top-left row.
- pos_col, in, COORD_W: sprite top-left column.
- pos_en, in, 1: sprite visible.
- bmp_we, in, 1: bitmap write strobe.
- bmp_spr, in, clog2(NUM_SPR): target sprite for bitmap write.
- bmp_addr, in, 2*log2(SPR_DIM): bitmap pixel index, row*SPR_DIM+col.
- bmp_data, in, PIX_W: bitmap pixel colour.
- frame_start, in, 1: one-cycle pulse at vertical blank.
- pix_valid, in, 1: active-video qualifier.
- pixel_row, in, COORD_W: current raster row.
- pixel_col, in, COORD_W: current raster column.
- bckgnd_pixel, in, PIX_W: background colour.
- pixel_out, out, PIX_W: composited colour.
- out_valid, out, 1: pix_valid delayed to match pixel_out.
- collision, out, NUM_SPR: sticky per-sprite collision flags.
- coll_clr, in, 1: clear all collision flags.

Function
REQ-003 Each sprite SHALL hold a shadow register set (row, col, en) written by pos_we, and an active set used for display.
REQ-004 On frame_start, all active sets SHALL be loaded from their shadow sets. If pos_we occurs in the same cycle, the active set SHALL take the pre-write shadow value and the new value SHALL remain in shadow.
REQ-005 Each sprite SHALL own an SPR_DIM*SPR_DIM x PIX_W bitmap RAM, written by bmp_we.
REQ-006 Bitmap RAM reads SHALL be read-first: a read and a write to the same address in one cycle returns the old data.
REQ-007 Sprite i SHALL be hit when all of the following hold; comparisons SHALL use COORD_W+1 bits so a sprite near the coordinate maximum does not wrap to 0:
- en is 1;
- spr_row <= pixel_row <= spr_row+SPR_DIM-1;
- spr_col <= pixel_col <= spr_col+SPR_DIM-1.
REQ-008 The bitmap index for a hit SHALL be (pixel_row-spr_row)*SPR_DIM + (pixel_col-spr_col).
REQ-009 Sprite i SHALL be opaque when it is hit and its bitmap pixel is not TRANSP_CLR.
REQ-010 pixel_out SHALL be selected as follows:
- the colour of the lowest-index opaque sprite, if any;
- otherwise bckgnd_pixel;
- 0 whenever pix_valid was 0.
REQ-011 The pipeline SHALL have fixed 2-cycle latency. Inputs sampled at edge N SHALL appear on pixel_out, out_valid and collision at edge N+2. The pipeline SHALL accept a new pixel every cycle with no stalls.
REQ-012 Position writes affecting the display SHALL take effect only after a frame_start, so there is no mid-frame tearing. Bitmap writes SHALL take effect immediately.

Reset
REQ-013 While rst_n is 0 at a rising edge, the following SHALL be cleared to 0: all shadow and active row/col/en registers, pipeline stages, pixel_out, out_valid and collision.
REQ-014 Bitmap RAM contents SHALL NOT be reset. Because all sprites reset disabled, stale RAM content is not visible.
REQ-015 Assertion of rst_n mid-frame or mid-pipeline SHALL discard in-flight pixels. Output SHALL resume with 2-cycle latency after release.

Configuration
REQ-016 When SPRITE_COLLISION_EN is defined, collision detection SHALL be compiled in:
- collision[i] SHALL set when pix_valid is 1, sprite i is opaque, and at least one other sprite is opaque at the same pixel;
- flags SHALL be sticky until coll_clr;
- if set and clear occur in the same cycle, set SHALL win.
REQ-017 When SPRITE_COLLISION_EN is undefined, collision SHALL be constant 0, coll_clr SHALL be ignored, and no collision logic SHALL be synthesised.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Opaque pixel: reset; write sprite0 bitmap all 4'hA; pos (row 100, col 200, en 1); frame_start; raster (100,200) with bckgnd 4'h3 -> pixel_out 4'hA two cycles later; (100,216) -> 4'h3.
- Transparency and priority: sprite0 bitmap 0 (transparent), sprite1 bitmap 4'h5, both at (10,10) -> 4'h5; then sprite0 bitmap 4'h7 -> 4'h7.
- Deferred position: pos_we moves sprite0 to (50,50) with no frame_start -> still drawn at old position; after frame_start -> drawn at (50,50). pos_we and frame_start in the same cycle -> old shadow value committed.
- Edge wrap: sprite at row 4090, col 0, COORD_W 12 -> pixel (2,0) shows background, not sprite.
- Collision (macro on): sprites 0 and 2 opaque and overlapping at (20,20) -> collision 4'b0101, which holds; coll_clr -> 0; coll_clr coincident with a new overlap -> stays 4'b0101. Macro off -> collision 0.
- Reset mid-line: rst_n low for 1 cycle during active video -> pixel_out 0 and out_valid 0 the next cycle, all sprites disabled.

Source files
------------

// File: rtl/sprite_engine_if.sv
// Sprite engine bus: position/bitmap write ports, raster input, composited output.
// The master drives the write and raster signals. The slave (the engine) returns the
// composited pixel, its valid flag and the collision flags.
interface sprite_engine_if #(
  parameter int NUM_SPR = 4,
  parameter int SPR_DIM = 16,
  parameter int PIX_W   = 4,
  parameter int COORD_W = 12
);
  localparam int SW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam int AW = 2 * $clog2(SPR_DIM);

  logic               pos_we;
  logic [SW-1:0]      pos_spr;
  logic [COORD_W-1:0] pos_row;
  logic [COORD_W-1:0] pos_col;
  logic               pos_en;
  logic               bmp_we;
  logic [SW-1:0]      bmp_spr;
  logic [AW-1:0]      bmp_addr;
  logic [PIX_W-1:0]   bmp_data;
  logic               frame_start;
  logic               pix_valid;
  logic [COORD_W-1:0] pixel_row;
  logic [COORD_W-1:0] pixel_col;
  logic [PIX_W-1:0]   bckgnd_pixel;
  logic [PIX_W-1:0]   pixel_out;
  logic               out_valid;
  logic [NUM_SPR-1:0] collision;
  logic               coll_clr;

  modport master (
    output pos_we, pos_spr, pos_row, pos_col, pos_en,
    output bmp_we, bmp_spr, bmp_addr, bmp_data,
    output frame_start, pix_valid, pixel_row, pixel_col, bckgnd_pixel, coll_clr,
    input  pixel_out, out_valid, collision
  );

  modport slave (
    input  pos_we, pos_spr, pos_row, pos_col, pos_en,
    input  bmp_we, bmp_spr, bmp_addr, bmp_data,
    input  frame_start, pix_valid, pixel_row, pixel_col, bckgnd_pixel, coll_clr,
    output pixel_out, out_valid, collision
  );
endinterface

// File: rtl/sprite_engine.sv
// Hardware sprite compositor. It has a fixed 2-cycle pipeline:
//   edge N   : hit test against the active position set; register the bitmap address
//   edge N+1 : read the bitmap RAM (read-first); carry hit, background and valid forward
//   edge N+2 : resolve priority and transparency; register pixel_out/out_valid/collision
// Position writes land in a shadow set. The active set copies the shadow set on
// frame_start, so a sprite never moves part-way through a frame.
// Optional feature: define SPRITE_COLLISION_EN to build the sticky per-sprite collision flags.
module sprite_engine #(
  parameter int NUM_SPR    = 4,
  parameter int SPR_DIM    = 16,
  parameter int PIX_W      = 4,
  parameter int COORD_W    = 12,
  parameter int TRANSP_CLR = 0
) (
  input logic            vga_clk,
  input logic            rst_n,
  sprite_engine_if.slave bus
);

  localparam int SW    = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam int DW    = $clog2(SPR_DIM);
  localparam int AW    = 2 * DW;
  localparam int DEPTH = SPR_DIM * SPR_DIM;
  localparam int CW    = COORD_W + 1;
  localparam logic [PIX_W-1:0] TC   = PIX_W'(TRANSP_CLR);
  localparam logic [CW-1:0]    SPAN = CW'(SPR_DIM - 1);

  logic [COORD_W-1:0] sh_row [NUM_SPR];
  logic [COORD_W-1:0] sh_col [NUM_SPR];
  logic [NUM_SPR-1:0] sh_en;
  logic [COORD_W-1:0] ac_row [NUM_SPR];
  logic [COORD_W-1:0] ac_col [NUM_SPR];
  logic [NUM_SPR-1:0] ac_en;

  logic [NUM_SPR-1:0] hit;
  logic [AW-1:0]      addr [NUM_SPR];

  logic [NUM_SPR-1:0] s1_hit;
  logic [AW-1:0]      s1_addr [NUM_SPR];
  logic [PIX_W-1:0]   s1_bg;
  logic               s1_valid;

  logic [PIX_W-1:0]   rd_data [NUM_SPR];
  logic [NUM_SPR-1:0] s2_hit;
  logic [PIX_W-1:0]   s2_bg;
  logic               s2_valid;

  logic [NUM_SPR-1:0] opaque;
  logic [PIX_W-1:0]   colour;

  logic [PIX_W-1:0]   pix_q;
  logic               valid_q;
  logic [NUM_SPR-1:0] coll_q;

  // Shadow positions take the writes; the active set copies the shadow set on frame_start.
  // A write in the same cycle as frame_start stays in the shadow set only.
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        sh_row[i] <= '0;
        sh_col[i] <= '0;
        ac_row[i] <= '0;
        ac_col[i] <= '0;
      end
      sh_en <= '0;
      ac_en <= '0;
    end else begin
      if (bus.frame_start) begin
        for (int i = 0; i < NUM_SPR; i++) begin
          ac_row[i] <= sh_row[i];
          ac_col[i] <= sh_col[i];
        end
        ac_en <= sh_en;
      end
      if (bus.pos_we) begin
        sh_row[bus.pos_spr] <= bus.pos_row;
        sh_col[bus.pos_spr] <= bus.pos_col;
        sh_en[bus.pos_spr]  <= bus.pos_en;
      end
    end
  end

  // The hit test uses one extra bit so a sprite near the coordinate maximum
  // does not wrap around to row/column 0.
  for (genvar g = 0; g < NUM_SPR; g++) begin : g_hit
    logic [CW-1:0] row_lo, col_lo, row_px, col_px;
    logic [DW-1:0] dr, dc;
    assign row_lo  = {1'b0, ac_row[g]};
    assign col_lo  = {1'b0, ac_col[g]};
    assign row_px  = {1'b0, bus.pixel_row};
    assign col_px  = {1'b0, bus.pixel_col};
    assign hit[g]  = ac_en[g] &&
                     (row_px >= row_lo) && (row_px <= row_lo + SPAN) &&
                     (col_px >= col_lo) && (col_px <= col_lo + SPAN);
    // Only the low DW bits of each offset reach the index. The bits above them
    // do not affect the difference in those low bits.
    assign dr      = bus.pixel_row[DW-1:0] - ac_row[g][DW-1:0];
    assign dc      = bus.pixel_col[DW-1:0] - ac_col[g][DW-1:0];
    assign addr[g] = {dr, dc};
  end

  // Each sprite has its own bitmap RAM. Contents are not reset.
  // The read register sees the pre-write data when a read and a write hit the same address.
  for (genvar g = 0; g < NUM_SPR; g++) begin : g_ram
    logic [PIX_W-1:0] mem [DEPTH];
    logic [PIX_W-1:0] rd_q;

    // Bitmap write port.
    always_ff @(posedge vga_clk) begin
      if (bus.bmp_we && (bus.bmp_spr == SW'(g)))
        mem[bus.bmp_addr] <= bus.bmp_data;
    end

    // Registered read for pipeline stage 2.
    always_ff @(posedge vga_clk) begin
      if (!rst_n) rd_q <= '0;
      else        rd_q <= mem[s1_addr[g]];
    end

    assign rd_data[g] = rd_q;
  end

  // Pipeline stages 1 and 2 carry the hit flags, background and valid.
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      s1_hit   <= '0;
      for (int i = 0; i < NUM_SPR; i++) s1_addr[i] <= '0;
      s1_bg    <= '0;
      s1_valid <= 1'b0;
      s2_hit   <= '0;
      s2_bg    <= '0;
      s2_valid <= 1'b0;
    end else begin
      s1_hit   <= hit;
      for (int i = 0; i < NUM_SPR; i++) s1_addr[i] <= addr[i];
      s1_bg    <= bus.bckgnd_pixel;
      s1_valid <= bus.pix_valid;
      s2_hit   <= s1_hit;
      s2_bg    <= s1_bg;
      s2_valid <= s1_valid;
    end
  end

  // Priority select. The scan runs downward, so the lowest-index opaque sprite wins.
  always_comb begin
    opaque = '0;
    colour = s2_bg;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      opaque[i] = s2_hit[i] && (rd_data[i] != TC);
      if (opaque[i]) colour = rd_data[i];
    end
  end

  // Output register. The pixel is forced to 0 outside active video.
  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      pix_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pix_q   <= s2_valid ? colour : '0;
      valid_q <= s2_valid;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [NUM_SPR-1:0] coll_set;

  // A sprite collides when it is opaque and at least one other sprite is opaque at the same pixel.
  always_comb begin
    coll_set = '0;
    for (int i = 0; i < NUM_SPR; i++)
      coll_set[i] = s2_valid && opaque[i] &&
                    ((opaque & ~(NUM_SPR'(1) << i)) != '0);
  end

  // The flags stay set until coll_clr. If a new collision arrives in the same cycle as coll_clr, the new collision is kept.
  always_ff @(posedge vga_clk) begin
    if (!rst_n)            coll_q <= '0;
    else if (bus.coll_clr) coll_q <= coll_set;
    else                   coll_q <= coll_q | coll_set;
  end
`else
  logic unused_coll_clr;
  assign unused_coll_clr = bus.coll_clr;
  assign coll_q          = '0;
`endif

  assign bus.pixel_out = pix_q;
  assign bus.out_valid = valid_q;
  assign bus.collision = coll_q;

endmodule

// File: tb/tb_sprite_engine.sv
// Testbench for sprite_engine: directed scenarios followed by a randomized run,
// compared against a pixel-level reference model.
// SPRITE_COLLISION_EN selects whether the collision flags are expected to operate.
module tb_sprite_engine;

  localparam int NSPR = 4;
  localparam int DIM  = 16;

  typedef struct {
    int pix;
    int valid;
    int cset;
  } exp_t;

  logic vga_clk;
  logic rst_n;
  sprite_engine_if bus ();

  sprite_engine dut (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial begin
    vga_clk = 1'b0;
    forever #5 vga_clk = ~vga_clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  int m_sh_row [NSPR];
  int m_sh_col [NSPR];
  int m_sh_en  [NSPR];
  int m_ac_row [NSPR];
  int m_ac_col [NSPR];
  int m_ac_en  [NSPR];
  int m_mem    [NSPR][DIM*DIM];
  int coll_m = 0;
  exp_t pipe[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, want, $time);
    end
  endtask

  // Reference pixel for the raster inputs now on the bus. It is computed from the sprite
  // rectangles with plain integer arithmetic, so coordinates never wrap.
  function automatic exp_t model_now();
    exp_t e;
    int   r, c, clr, nop, vec;
    bit   found;
    r = int'(bus.pixel_row);
    c = int'(bus.pixel_col);
    e.pix = int'(bus.bckgnd_pixel);
    nop = 0; vec = 0; found = 0;
    for (int s = 0; s < NSPR; s++) begin
      if (m_ac_en[s] != 0 &&
          r >= m_ac_row[s] && r < m_ac_row[s] + DIM &&
          c >= m_ac_col[s] && c < m_ac_col[s] + DIM) begin
        clr = m_mem[s][(r - m_ac_row[s]) * DIM + (c - m_ac_col[s])];
        if (clr != 0) begin
          nop++;
          vec |= (1 << s);
          if (!found) begin
            e.pix = clr;
            found = 1;
          end
        end
      end
    end
    e.valid = bus.pix_valid ? 1 : 0;
    e.cset  = (bus.pix_valid && nop >= 2) ? vec : 0;
    if (!bus.pix_valid) e.pix = 0;
    return e;
  endfunction

  // Advance one clock. The model's view of this edge is compared with the DUT outputs.
  task automatic tick();
    exp_t e, f, z;
    z = '{pix: 0, valid: 0, cset: 0};
    e = model_now();
    @(posedge vga_clk);
    if (rst_n == 1'b0) begin
      for (int s = 0; s < NSPR; s++) begin
        m_sh_row[s] = 0; m_sh_col[s] = 0; m_sh_en[s] = 0;
        m_ac_row[s] = 0; m_ac_col[s] = 0; m_ac_en[s] = 0;
      end
      coll_m = 0;
      pipe.delete();
      pipe.push_back(z);
      pipe.push_back(z);
      f = z;
    end else begin
      pipe.push_back(e);
      f = pipe.pop_front();
`ifdef SPRITE_COLLISION_EN
      coll_m = bus.coll_clr ? f.cset : (coll_m | f.cset);
`endif
      if (bus.frame_start)
        for (int s = 0; s < NSPR; s++) begin
          m_ac_row[s] = m_sh_row[s];
          m_ac_col[s] = m_sh_col[s];
          m_ac_en[s]  = m_sh_en[s];
        end
      if (bus.pos_we) begin
        m_sh_row[int'(bus.pos_spr)] = int'(bus.pos_row);
        m_sh_col[int'(bus.pos_spr)] = int'(bus.pos_col);
        m_sh_en[int'(bus.pos_spr)]  = bus.pos_en ? 1 : 0;
      end
      if (bus.bmp_we) m_mem[int'(bus.bmp_spr)][int'(bus.bmp_addr)] = int'(bus.bmp_data);
    end
    #1;
    chk("pixel_out", 32'(bus.pixel_out), 32'(f.pix));
    chk("out_valid", 32'(bus.out_valid), 32'(f.valid));
    chk("collision", 32'(bus.collision), 32'(coll_m));
  endtask

  task automatic fill(int spr, int clr, bit rnd);
    bus.pix_valid = 1'b0;
    for (int a = 0; a < DIM*DIM; a++) begin
      bus.bmp_we   = 1'b1;
      bus.bmp_spr  = 2'(spr);
      bus.bmp_addr = 8'(a);
      if (rnd) bus.bmp_data = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      else     bus.bmp_data = 4'(clr);
      tick();
    end
    bus.bmp_we = 1'b0;
  endtask

  task automatic set_pos(int spr, int row, int col, bit en, bit with_frame);
    bus.pos_we      = 1'b1;
    bus.pos_spr     = 2'(spr);
    bus.pos_row     = 12'(row);
    bus.pos_col     = 12'(col);
    bus.pos_en      = en;
    bus.frame_start = with_frame;
    tick();
    bus.pos_we      = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  // Drive one valid pixel, then check the output two edges later against a hand-derived constant.
  task automatic probe(string tag, int row, int col, int bg, int want);
    bus.pix_valid    = 1'b1;
    bus.pixel_row    = 12'(row);
    bus.pixel_col    = 12'(col);
    bus.bckgnd_pixel = 4'(bg);
    tick();
    bus.pix_valid = 1'b0;
    tick();
    tick();
    chk(tag, 32'(bus.pixel_out), 32'(want));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_c;
`ifdef SPRITE_COLLISION_EN
    exp_c = 4'b0101;
`else
    exp_c = 4'b0000;
`endif
    pipe.push_back('{pix: 0, valid: 0, cset: 0});
    pipe.push_back('{pix: 0, valid: 0, cset: 0});
    rst_n = 1'b0;
    bus.pos_we = 1'b0; bus.pos_spr = '0; bus.pos_row = '0; bus.pos_col = '0; bus.pos_en = 1'b0;
    bus.bmp_we = 1'b0; bus.bmp_spr = '0; bus.bmp_addr = '0; bus.bmp_data = '0;
    bus.frame_start = 1'b0; bus.pix_valid = 1'b0; bus.pixel_row = '0; bus.pixel_col = '0;
    bus.bckgnd_pixel = '0; bus.coll_clr = 1'b0;
    tick();
    tick();
    chk("reset_pixel", 32'(bus.pixel_out), 32'h0);
    chk("reset_valid", 32'(bus.out_valid), 32'h0);
    rst_n = 1'b1;
    for (int s = 0; s < NSPR; s++) fill(s, 0, 1'b0);

    // Opaque pixel
    fill(0, 4'hA, 1'b0);
    set_pos(0, 100, 200, 1'b1, 1'b0);
    frame();
    probe("opaque_hit", 100, 200, 3, 4'hA);
    probe("right_edge_in", 115, 215, 3, 4'hA);
    probe("past_right_edge", 100, 216, 3, 4'h3);
    probe("above_top", 99, 200, 3, 4'h3);

    // Transparency and priority
    fill(0, 0, 1'b0);
    fill(1, 5, 1'b0);
    set_pos(0, 10, 10, 1'b1, 1'b0);
    set_pos(1, 10, 10, 1'b1, 1'b0);
    frame();
    probe("transparent_top", 12, 12, 3, 4'h5);
    fill(0, 7, 1'b0);
    probe("priority_low_idx", 12, 12, 3, 4'h7);

    // Deferred position update
    set_pos(1, 10, 10, 1'b0, 1'b0);
    frame();
    set_pos(0, 50, 50, 1'b1, 1'b0);
    probe("deferred_old_pos", 10, 10, 3, 4'h7);
    probe("deferred_new_pos", 50, 50, 3, 4'h3);
    frame();
    probe("committed_new", 50, 50, 3, 4'h7);
    probe("committed_old", 10, 10, 3, 4'h3);
    set_pos(0, 30, 30, 1'b1, 1'b1);
    probe("same_cycle_old", 50, 50, 3, 4'h7);
    probe("same_cycle_new", 30, 30, 3, 4'h3);
    frame();
    probe("later_commit", 30, 30, 3, 4'h7);

    // Sprite at the bottom of the coordinate range must not wrap to row 0
    set_pos(0, 4090, 0, 1'b1, 1'b0);
    frame();
    probe("edge_wrap", 2, 0, 3, 4'h3);
    probe("edge_bottom", 4095, 0, 3, 4'h7);

    // Collision
    fill(2, 9, 1'b0);
    set_pos(0, 20, 20, 1'b1, 1'b0);
    set_pos(2, 20, 20, 1'b1, 1'b0);
    frame();
    bus.coll_clr = 1'b1; tick(); bus.coll_clr = 1'b0;
    chk("coll_cleared", 32'(bus.collision), 32'h0);
    probe("coll_pixel", 20, 20, 3, 4'h7);
    chk("coll_set", 32'(bus.collision), 32'(exp_c));
    tick();
    chk("coll_sticky", 32'(bus.collision), 32'(exp_c));
    bus.coll_clr = 1'b1; tick(); bus.coll_clr = 1'b0;
    chk("coll_clr", 32'(bus.collision), 32'h0);
    bus.pix_valid = 1'b1; bus.pixel_row = 12'd20; bus.pixel_col = 12'd20;
    tick();
    bus.pix_valid = 1'b0;
    tick();
    bus.coll_clr = 1'b1; tick(); bus.coll_clr = 1'b0;
    chk("coll_set_wins", 32'(bus.collision), 32'(exp_c));

    // Reset in the middle of active video
    bus.pix_valid = 1'b1; bus.pixel_row = 12'd20; bus.pixel_col = 12'd20; bus.bckgnd_pixel = 4'h3;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midreset_pixel", 32'(bus.pixel_out), 32'h0);
    chk("midreset_valid", 32'(bus.out_valid), 32'h0);
    chk("midreset_coll", 32'(bus.collision), 32'h0);
    bus.pix_valid = 1'b0;
    probe("disabled_after_reset", 20, 20, 3, 4'h3);

    // Randomized traffic checked against the model
    for (int s = 0; s < NSPR; s++) fill(s, 0, 1'b1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 600 == 300) begin
        bus.pos_we = 1'b0; bus.frame_start = 1'b0; bus.coll_clr = 1'b0; rst_n = 1'b1;
        bus.pix_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
          bus.bmp_we   = 1'b1;
          bus.bmp_spr  = 2'($urandom_range(0, NSPR - 1));
          bus.bmp_addr = 8'($urandom_range(0, DIM*DIM - 1));
          bus.bmp_data = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
          tick();
        end
        bus.bmp_we = 1'b0;
      end
      rst_n            = ($urandom_range(0, 399) != 0);
      bus.pos_we       = ($urandom_range(0, 9) == 0);
      bus.pos_spr      = 2'($urandom_range(0, NSPR - 1));
      bus.pos_row      = 12'($urandom_range(0, 60));
      bus.pos_col      = 12'($urandom_range(0, 60));
      bus.pos_en       = ($urandom_range(0, 3) != 0);
      bus.frame_start  = ($urandom_range(0, 29) == 0);
      bus.pix_valid    = ($urandom_range(0, 4) != 0);
      bus.pixel_row    = 12'($urandom_range(0, 80));
      bus.pixel_col    = 12'($urandom_range(0, 80));
      bus.bckgnd_pixel = 4'($urandom_range(0, 15));
      bus.coll_clr     = ($urandom_range(0, 15) == 0);
      tick();
    end
    rst_n = 1'b1;
    bus.pos_we = 1'b0; bus.frame_start = 1'b0; bus.pix_valid = 1'b0; bus.coll_clr = 1'b0;
    tick();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
